// File: rtl/mem_bus_ctrl_pkg.sv
// Shared address map, FSM/region encodings and decode helpers for the memory bus controller.
package mem_bus_ctrl_pkg;

    localparam int WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] ROM_SIZE = 16'd256;
    localparam logic [WORD_SIZE-1:0] RAM_SIZE = 16'd256;
    localparam logic [WORD_SIZE-1:0] RAM_BASE = 16'h1000;
    localparam int ROM_AW = $clog2(ROM_SIZE);
    localparam int RAM_AW = $clog2(RAM_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_ROM  = 2'd0,
        REG_RAM  = 2'd1,
        REG_NONE = 2'd2
    } region_t;

    function automatic region_t decode_region(input logic [WORD_SIZE-1:0] addr);
        if (addr < ROM_SIZE)
            return REG_ROM;
        if (addr >= RAM_BASE && (addr - RAM_BASE) < RAM_SIZE)
            return REG_RAM;
        return REG_NONE;
    endfunction

    // Writes succeed only into RAM; reads fail only when unmapped.
    function automatic logic access_err(input region_t region, input logic is_write,
                                        input logic conflict);
        return conflict || (is_write ? (region != REG_RAM) : (region == REG_NONE));
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable 3-bit saturating down-counter; done flags the last wait cycle.
module mem_wait_ctr (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_done
);

    logic [2:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= 3'd0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && r_count != 3'd0)
            r_count <= r_count - 3'd1;
    end

    assign o_done = (r_count == 3'd1);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-ROM/RAM bus controller with per-region wait states, error signalling and ROM program load.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] addr_bus,
    inout  wire  [7:0]           ext_data_bus,
    input  logic                 read_en,
    input  logic                 write_en,
    output logic                 mem_ready,
    output logic                 bus_err,
    input  logic                 prog_we,
    input  logic [WORD_SIZE-1:0] prog_addr,
    input  logic [7:0]           prog_data
);

    state_t                r_state;
    logic [WORD_SIZE-1:0]  r_addr;
    logic                  r_is_write;
    logic                  r_conflict;
    region_t               r_region;
    logic [7:0]            r_wdata;
    logic                  r_mem_ready;
    logic                  r_bus_err;
    logic                  r_drive;

    logic [7:0] rom [ROM_SIZE];
    logic [7:0] ram [RAM_SIZE];

    logic       w_any_req;
    logic       w_single_req;
    logic       w_conflict;
    region_t    w_region;
    logic [2:0] w_wait;
    logic       w_ctr_done;
    logic       w_ram_we;
    logic       w_prog_we;
    logic [7:0] w_rd_data;

    assign w_any_req    = read_en | write_en;
    assign w_single_req = read_en ^ write_en;
    assign w_conflict   = read_en & write_en;
    assign w_region     = decode_region(addr_bus);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    // Unmapped accesses carry no wait states of their own.
    always_comb begin
        w_wait = 3'd0;
        case (w_region)
            REG_ROM: w_wait = 3'(ROM_WAIT);
            REG_RAM: w_wait = 3'(RAM_WAIT);
            default: w_wait = 3'd0;
        endcase
    end

    mem_wait_ctr u_wait_ctr (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_load     (r_state == IDLE && w_single_req),
        .i_load_val (w_wait),
        .i_dec      (r_state == WAIT),
        .o_done     (w_ctr_done)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_conflict  <= 1'b0;
            r_region    <= REG_NONE;
            r_wdata     <= 8'h00;
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
            r_drive     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_addr     <= addr_bus;
                        r_is_write <= write_en;
                        r_conflict <= w_conflict;
                        r_region   <= w_region;
                        r_wdata    <= ext_data_bus;
                        if (w_conflict || w_wait == 3'd0) begin
                            r_state     <= RESP;
                            r_mem_ready <= 1'b1;
                            r_bus_err   <= access_err(w_region, write_en, w_conflict);
                            r_drive     <= read_en && !write_en;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_ctr_done) begin
                        r_state     <= RESP;
                        r_mem_ready <= 1'b1;
                        r_bus_err   <= access_err(r_region, r_is_write, r_conflict);
                        r_drive     <= !r_is_write && !r_conflict;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_mem_ready <= 1'b0;
                    r_bus_err   <= 1'b0;
                    r_drive     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset forces r_state to IDLE asynchronously, which also cancels a pending RAM write.
    assign w_ram_we  = (r_state == RESP) && r_is_write && !r_conflict && (r_region == REG_RAM);
    assign w_prog_we = prog_we && (r_state == IDLE) && !w_any_req && (prog_addr < ROM_SIZE);

    // NOTE: memory arrays carry no reset; contents survive reset and map onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (w_ram_we)
            ram[RAM_AW'(r_addr - RAM_BASE)] <= r_wdata;
        if (w_prog_we)
            rom[ROM_AW'(prog_addr)] <= prog_data;
    end

    always_comb begin
        w_rd_data = 8'hFF;
        case (r_region)
            REG_ROM: w_rd_data = rom[ROM_AW'(r_addr)];
            REG_RAM: w_rd_data = ram[RAM_AW'(r_addr - RAM_BASE)];
            default: w_rd_data = 8'hFF;
        endcase
    end

    assign ext_data_bus = r_drive ? w_rd_data : 8'hzz;
    assign mem_ready    = r_mem_ready;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl: default-wait instance plus a RAM_WAIT=2 instance.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_bus, prog_addr;
    logic        read_en, write_en, prog_we;
    logic [7:0]  prog_data;
    logic        mem_ready, bus_err;
    wire  [7:0]  ext_data_bus;
    logic        tb_oe;
    logic [7:0]  tb_dout;

    logic [15:0] addr_b;
    logic        read_en_b, write_en_b;
    logic        mem_ready_b, bus_err_b;
    wire  [7:0]  ext_data_bus_b;
    logic        tb_oe_b;
    logic [7:0]  tb_dout_b;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] RAM_A = RAM_BASE + 16'd100;
    localparam logic [15:0] RAM_B = RAM_BASE + 16'd5;

    // The weak pull makes a released bus read as 8'h00.
    assign ext_data_bus   = tb_oe   ? tb_dout   : 8'hzz;
    assign ext_data_bus_b = tb_oe_b ? tb_dout_b : 8'hzz;
    pulldown (ext_data_bus);
    pulldown (ext_data_bus_b);

    always #5 clk = ~clk;

    mem_bus_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .addr_bus     (addr_bus),
        .ext_data_bus (ext_data_bus),
        .read_en      (read_en),
        .write_en     (write_en),
        .mem_ready    (mem_ready),
        .bus_err      (bus_err),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data)
    );

    mem_bus_ctrl #(.ROM_WAIT(0), .RAM_WAIT(2)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .addr_bus     (addr_b),
        .ext_data_bus (ext_data_bus_b),
        .read_en      (read_en_b),
        .write_en     (write_en_b),
        .mem_ready    (mem_ready_b),
        .bus_err      (bus_err_b),
        .prog_we      (1'b0),
        .prog_addr    (16'h0000),
        .prog_data    (8'h00)
    );

    task automatic prog(input logic [15:0] a, input logic [7:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    // lat counts edges from the accept edge to the edge that raises mem_ready (wait + 1).
    task automatic access(input bit use_b, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [7:0] wd, output int lat, output logic [7:0] rdata,
                          output logic err, output logic quiet_ok);
        logic rdy;
        logic [7:0] bus;
        lat = 0; rdata = 8'h00; err = 1'b0; quiet_ok = 1'b1; rdy = 1'b0;
        if (use_b) begin
            read_en_b = rd; write_en_b = wr; addr_b = a; tb_dout_b = wd; tb_oe_b = wr && !rd;
        end else begin
            read_en = rd; write_en = wr; addr_bus = a; tb_dout = wd; tb_oe = wr && !rd;
        end
        while (!rdy && lat < 16) begin
            @(posedge clk); #1;
            lat++;
            rdy = use_b ? mem_ready_b : mem_ready;
            bus = use_b ? ext_data_bus_b : ext_data_bus;
            if (!rdy && rd && bus !== 8'h00) quiet_ok = 1'b0;
        end
        if (rdy) begin
            rdata = use_b ? ext_data_bus_b : ext_data_bus;
            err   = use_b ? bus_err_b : bus_err;
        end else begin
            lat = -1;
        end
        read_en = 1'b0; write_en = 1'b0; tb_oe = 1'b0;
        read_en_b = 1'b0; write_en_b = 1'b0; tb_oe_b = 1'b0;
        @(posedge clk); #1;
        rdy = use_b ? mem_ready_b : mem_ready;
        bus = use_b ? ext_data_bus_b : ext_data_bus;
        if (rdy || bus !== 8'h00) quiet_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_err); end
        checks++; if (ext_data_bus !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h want released", ext_data_bus); end
        checks++; if (mem_ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready_b: got %b want 0", mem_ready_b); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rom_read();
        int lat; logic [7:0] d; logic e, q;
        prog(16'h0000, 8'h42);
        access(0, 1, 0, 16'h0000, 8'h00, lat, d, e, q);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rom_read_lat: got %0d want 2", lat); end
        checks++; if (d !== 8'h42) begin errors++; $display("FAIL rom_read_data: got %h want 42", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rom_read_err: got %b want 0", e); end
        checks++; if (q !== 1'b1) begin errors++; $display("FAIL rom_read_quiet: bus driven or ready outside RESP"); end
    endtask

    task automatic test_ram_write_read();
        int lat; logic [7:0] d; logic e, q;
        access(0, 0, 1, RAM_A, 8'h4A, lat, d, e, q);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ram_wr_lat: got %0d want 1", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_wr_err: got %b want 0", e); end
        access(0, 1, 0, RAM_A, 8'h00, lat, d, e, q);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ram_rd_lat: got %0d want 1", lat); end
        checks++; if (d !== 8'h4A) begin errors++; $display("FAIL ram_rd_data: got %h want 4a", d); end
        checks++; if (q !== 1'b1) begin errors++; $display("FAIL ram_rd_quiet: bus driven or ready outside RESP"); end
    endtask

    task automatic test_rom_write_err();
        int lat; logic [7:0] d; logic e, q;
        prog(16'h0003, 8'h33);
        access(0, 0, 1, 16'h0003, 8'h55, lat, d, e, q);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rom_wr_lat: got %0d want 2", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rom_wr_err: got %b want 1", e); end
        access(0, 1, 0, 16'h0003, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL rom_wr_keep: got %h want 33", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rom_rd3_err: got %b want 0", e); end
    endtask

    task automatic test_conflict();
        int lat; logic [7:0] d; logic e, q;
        access(0, 1, 1, RAM_A, 8'h77, lat, d, e, q);
        checks++; if (lat !== 1) begin errors++; $display("FAIL conflict_lat: got %0d want 1", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b want 1", e); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL conflict_bus: got %h want released", d); end
        checks++; if (q !== 1'b1) begin errors++; $display("FAIL conflict_quiet: bus driven or ready outside RESP"); end
        access(0, 1, 0, RAM_A, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'h4A) begin errors++; $display("FAIL conflict_ram_keep: got %h want 4a", d); end
    endtask

    task automatic test_unmapped();
        int lat; logic [7:0] d; logic e, q;
        access(0, 1, 0, 16'hF000, 8'h00, lat, d, e, q);
        checks++; if (lat !== 1) begin errors++; $display("FAIL unmap_lat: got %0d want 1", lat); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmap_data: got %h want ff", d); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmap_err: got %b want 1", e); end
        checks++; if (q !== 1'b1) begin errors++; $display("FAIL unmap_quiet: bus driven or ready outside RESP"); end
        access(0, 1, 0, 16'h0100, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL unmap_rom_end: got %h/%b want ff/1", d, e); end
        access(0, 1, 0, RAM_BASE + RAM_SIZE, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL unmap_ram_end: got %h/%b want ff/1", d, e); end
        access(0, 0, 1, 16'h0100, 8'h12, lat, d, e, q);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmap_wr_err: got %b want 1", e); end
    endtask

    task automatic test_prog_guard();
        int lat; logic [7:0] d; logic e, q;
        prog(16'h0005, 8'h5A);
        prog_addr = 16'h0005; prog_data = 8'hA5; prog_we = 1'b1;
        access(0, 1, 0, 16'h0005, 8'h00, lat, d, e, q);
        prog_we = 1'b0;
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL prog_busy_read: got %h want 5a", d); end
        prog(16'h0105, 8'hEE);
        access(0, 1, 0, 16'h0005, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL prog_blocked: got %h want 5a", d); end
        prog(16'h00FF, 8'hC3);
        access(0, 1, 0, 16'h00FF, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'hC3 || e !== 1'b0) begin errors++; $display("FAIL prog_last: got %h/%b want c3/0", d, e); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seen;
        logic [7:0] d0, d2;
        read_en = 1'b1; addr_bus = RAM_A;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen[i] = mem_ready;
            if (i == 0) d0 = ext_data_bus;
            if (i == 2) d2 = ext_data_bus;
        end
        read_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (seen !== 4'b0101) begin errors++; $display("FAIL b2b_ready: got %b want 0101", seen); end
        checks++; if (d0 !== 8'h4A || d2 !== 8'h4A) begin errors++; $display("FAIL b2b_data: got %h %h want 4a 4a", d0, d2); end
    endtask

    task automatic test_reset_in_resp();
        int lat; logic [7:0] d; logic e, q;
        write_en = 1'b1; addr_bus = RAM_A; tb_dout = 8'h99; tb_oe = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL resp_enter: got %b want 1", mem_ready); end
        reset = 1'b1;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL resp_async_rst: got %b want 0", mem_ready); end
        write_en = 1'b0; tb_oe = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        access(0, 1, 0, RAM_A, 8'h00, lat, d, e, q);
        checks++; if (d !== 8'h4A) begin errors++; $display("FAIL resp_abort_keep: got %h want 4a", d); end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [7:0] d; logic e, q;
        logic pulse;
        access(1, 0, 1, RAM_B, 8'h11, lat, d, e, q);
        checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL wait_wr_lat: got %0d/%b want 3/0", lat, e); end
        write_en_b = 1'b1; addr_b = RAM_B; tb_dout_b = 8'hAA; tb_oe_b = 1'b1;
        @(posedge clk); #1;
        pulse = mem_ready_b;
        reset = 1'b1;
        #1;
        write_en_b = 1'b0; tb_oe_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset = 1'b0;
            @(posedge clk); #1;
            pulse = pulse | mem_ready_b;
        end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL wait_abort_ready: got %b want 0", pulse); end
        access(1, 1, 0, RAM_B, 8'h00, lat, d, e, q);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wait_abort_idle: got %0d want 3", lat); end
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL wait_abort_keep: got %h want 11", d); end
    endtask

    initial begin
        reset = 1'b1;
        addr_bus = '0; read_en = 1'b0; write_en = 1'b0; tb_oe = 1'b0; tb_dout = 8'h00;
        prog_we = 1'b0; prog_addr = '0; prog_data = 8'h00;
        addr_b = '0; read_en_b = 1'b0; write_en_b = 1'b0; tb_oe_b = 1'b0; tb_dout_b = 8'h00;
        test_reset();
        test_rom_read();
        test_ram_write_read();
        test_rom_write_err();
        test_conflict();
        test_unmapped();
        test_prog_guard();
        test_back_to_back();
        test_reset_in_resp();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
